output_pooling_reader: RTL and testbench

- Read-side engine for the pooled-output BRAM bank set.
- Walks a channel range and an N x N pooled tile, and issues bank-select/read-address pairs to the BRAMs.
- Absorbs the fixed BRAM read latency and streams words out on a valid/ready interface with backpressure.
- Sits between the pooled-output memory and the result-unload path (DMA/AXI-stream packer).

---
 rtl/output_pooling_pkg.sv | 32 +++
 rtl/output_pooling_reader_if.sv | 36 +++
 rtl/output_pooling_fifo.sv | 51 +++++
 rtl/output_pooling_reader.sv | 171 +++++++++++++++++
 tb/tb_output_pooling_reader.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/output_pooling_pkg.sv
// Shared definitions for the pooled-output BRAM read and write sides.
// The state encoding, bank-select width and address formula live here,
// so the reader and the write-side decoder always agree on memory layout.
package output_pooling_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_RST = 3'd1,
      ST_ISSUE    = 3'd2,
      ST_DRAIN    = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   localparam int OUTPUT_BRAM_NUM_DEFAULT = 4;
   localparam int BANK_LOG2_DEFAULT       = $clog2(OUTPUT_BRAM_NUM_DEFAULT);

   // Number of channel LSBs that select a bank (bank count is a power of two).
   function automatic int unsigned bank_log2(input int unsigned num);
      return $clog2(num);
   endfunction

   // Word address of (ch,row,col) inside its bank for an n x n pooled tile.
   // Channels sharing a bank are stacked tile after tile.
   function automatic logic [31:0] pool_address(input logic [31:0] ch,
                                                input logic [31:0] n,
                                                input logic [31:0] row,
                                                input logic [31:0] col,
                                                input int unsigned bank_bits);
      return ((ch >> bank_bits) * n * n) + (row * n) + col;
   endfunction

endpackage

// File: rtl/output_pooling_reader_if.sv
// Control, BRAM-read and output-stream signals of the pooled-output reader.
// slave is the reader's view; master is the view of whoever drives it.
interface output_pooling_reader_if #(
   parameter int DATA_WIDTH                = 32,
   parameter int OUTPUT_CHANNEL_WIDTH      = 7,
   parameter int OUTPUT_COL_WIDTH          = 2,
   parameter int OUTPUT_BRAM_NUM           = 4,
   parameter int OUTPUT_BRAM_ADDRESS_WIDTH = 11
);
   logic                                 i_start;
   logic [OUTPUT_CHANNEL_WIDTH-1:0]      i_start_channel;
   logic [OUTPUT_CHANNEL_WIDTH-1:0]      i_end_channel;
   logic [OUTPUT_COL_WIDTH-1:0]          i_pool_size;
   logic                                 i_reset_busy;
   logic [OUTPUT_BRAM_NUM-1:0]           o_renable;
   logic [OUTPUT_BRAM_ADDRESS_WIDTH-1:0] o_raddress;
   logic [DATA_WIDTH-1:0]                i_bram_data;
   logic [DATA_WIDTH-1:0]                o_data;
   logic                                 o_valid;
   logic                                 i_ready;
   logic                                 o_last;
   logic                                 o_busy;
   logic                                 o_done;

   modport slave (
      input  i_start, i_start_channel, i_end_channel, i_pool_size,
             i_reset_busy, i_bram_data, i_ready,
      output o_renable, o_raddress, o_data, o_valid, o_last, o_busy, o_done
   );

   modport master (
      output i_start, i_start_channel, i_end_channel, i_pool_size,
             i_reset_busy, i_bram_data, i_ready,
      input  o_renable, o_raddress, o_data, o_valid, o_last, o_busy, o_done
   );
endinterface

// File: rtl/output_pooling_fifo.sv
// Small synchronous skid FIFO with occupancy count. Storage is not reset;
// only pointers and count are, so an abort empties it immediately.
module output_pooling_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign do_push = push && (int'(count) < DEPTH);
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // storage write, no reset on data
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // pointer and occupancy bookkeeping; push+pop together leaves count unchanged
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (int'(wr_ptr) == DEPTH - 1) ? '0 : wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= (int'(rd_ptr) == DEPTH - 1) ? '0 : rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/output_pooling_reader.sv
// Read-side engine for the pooled-output BRAM banks. Walks channels x rows x
// cols, issues one-hot bank reads, tracks reads in flight through the fixed
// BRAM latency and streams results out through a credit-protected skid FIFO.
module output_pooling_reader
   import output_pooling_pkg::*;
#(
   parameter int DATA_WIDTH                = 32,
   parameter int OUTPUT_CHANNEL_WIDTH      = 7,
   parameter int OUTPUT_COL_WIDTH          = 2,
   parameter int OUTPUT_BRAM_NUM           = 4,
   parameter int OUTPUT_BRAM_DEPTH         = 1152,
   parameter int OUTPUT_BRAM_ADDRESS_WIDTH = $clog2(OUTPUT_BRAM_DEPTH),
   parameter int READ_LATENCY              = 2,
   parameter int FIFO_DEPTH                = READ_LATENCY + 2
) (
   input  logic i_clock,
   input  logic i_reset,
   output_pooling_reader_if.slave bus
);
   localparam int CH_W      = OUTPUT_CHANNEL_WIDTH + 1;
   localparam int BANK_BITS = bank_log2(OUTPUT_BRAM_NUM);
   localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
   localparam int FLIGHT_W  = $clog2(READ_LATENCY + 2);
   localparam logic [CH_W-1:0] BANK_MASK = CH_W'(OUTPUT_BRAM_NUM - 1);

   state_t state;
   state_t state_next;

   logic [OUTPUT_CHANNEL_WIDTH-1:0]      start_ch;
   logic [OUTPUT_CHANNEL_WIDTH-1:0]      end_ch;
   logic [OUTPUT_COL_WIDTH-1:0]          pool_n;
   logic [OUTPUT_COL_WIDTH-1:0]          n_minus1;
   logic [CH_W-1:0]                      ch_cnt;
   logic [OUTPUT_COL_WIDTH-1:0]          row_cnt;
   logic [OUTPUT_COL_WIDTH-1:0]          col_cnt;
   logic                                 degenerate;
   logic                                 final_issue;
   logic                                 credit_ok;
   logic                                 issue;
   logic [OUTPUT_BRAM_NUM-1:0]           renable;
   logic [OUTPUT_BRAM_ADDRESS_WIDTH-1:0] raddress;
   logic                                 vld_p0;
   logic                                 last_p0;
   logic [READ_LATENCY-1:0]              vld_pipe;
   logic [READ_LATENCY-1:0]              last_pipe;
   logic [FLIGHT_W-1:0]                  in_flight;
   logic [CNT_W-1:0]                     fifo_count;
   logic                                 fifo_empty;
   logic                                 fifo_pop;
   logic [DATA_WIDTH:0]                  fifo_head;
   logic                                 last_accept;

   assign n_minus1    = pool_n - OUTPUT_COL_WIDTH'(1);
   assign degenerate  = (start_ch > end_ch) || (pool_n == '0);
   assign final_issue = (ch_cnt == {1'b0, end_ch}) && (row_cnt == n_minus1) && (col_cnt == n_minus1);
   assign credit_ok   = (int'(fifo_count) + int'(in_flight)) < FIFO_DEPTH;
   // The first read may go out on the same cycle WAIT_RST sees reset-busy low.
   assign issue       = ((state == ST_WAIT_RST && !degenerate) || state == ST_ISSUE)
                        && !bus.i_reset_busy && credit_ok;
   assign fifo_pop    = !fifo_empty && bus.i_ready;
   assign last_accept = fifo_pop && fifo_head[DATA_WIDTH];

   // count reads between issue and FIFO write (issue register plus latency pipe)
   always_comb begin
      in_flight = FLIGHT_W'(vld_p0);
      for (int i = 0; i < READ_LATENCY; i++) in_flight = in_flight + FLIGHT_W'(vld_pipe[i]);
   end

   // state register
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) state <= ST_IDLE;
      else         state <= state_next;
   end

   // next-state logic
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:     if (bus.i_start) state_next = ST_WAIT_RST;
         ST_WAIT_RST: begin
            if (degenerate)                state_next = ST_DONE;
            else if (issue && final_issue) state_next = ST_DRAIN;
            else if (!bus.i_reset_busy)    state_next = ST_ISSUE;
         end
         ST_ISSUE:    if (issue && final_issue) state_next = ST_DRAIN;
         ST_DRAIN:    if (last_accept && in_flight == '0) state_next = ST_DONE;
         ST_DONE:     state_next = ST_IDLE;
         default:     state_next = ST_IDLE;
      endcase
   end

   // config latch on start and channel/row/col walk on each issued read
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         start_ch <= '0;
         end_ch   <= '0;
         pool_n   <= '0;
         ch_cnt   <= '0;
         row_cnt  <= '0;
         col_cnt  <= '0;
      end else if (state == ST_IDLE && bus.i_start) begin
         start_ch <= bus.i_start_channel;
         end_ch   <= bus.i_end_channel;
         pool_n   <= bus.i_pool_size;
         ch_cnt   <= {1'b0, bus.i_start_channel};
         row_cnt  <= '0;
         col_cnt  <= '0;
      end else if (issue) begin
         if (col_cnt == n_minus1) begin
            col_cnt <= '0;
            if (row_cnt == n_minus1) begin
               row_cnt <= '0;
               ch_cnt  <= ch_cnt + CH_W'(1);
            end else begin
               row_cnt <= row_cnt + OUTPUT_COL_WIDTH'(1);
            end
         end else begin
            col_cnt <= col_cnt + OUTPUT_COL_WIDTH'(1);
         end
      end
   end

   // ---- stage p0: registered bank enable/address, then BRAM latency pipe ----
   // registered read port plus valid/last tracking through the BRAM latency
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         renable   <= '0;
         raddress  <= '0;
         vld_p0    <= 1'b0;
         last_p0   <= 1'b0;
         vld_pipe  <= '0;
         last_pipe <= '0;
      end else begin
         renable <= issue ? (OUTPUT_BRAM_NUM'(1) << (ch_cnt & BANK_MASK)) : '0;
         if (issue)
            raddress <= OUTPUT_BRAM_ADDRESS_WIDTH'(pool_address(32'(ch_cnt), 32'(pool_n),
                                                   32'(row_cnt), 32'(col_cnt), BANK_BITS));
         vld_p0       <= issue;
         last_p0      <= issue && final_issue;
         vld_pipe[0]  <= vld_p0;
         last_pipe[0] <= last_p0;
         for (int i = 1; i < READ_LATENCY; i++) begin
            vld_pipe[i]  <= vld_pipe[i-1];
            last_pipe[i] <= last_pipe[i-1];
         end
      end
   end

   // ---- FIFO write: BRAM data captured at the end of the latency pipe ----
   output_pooling_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (i_clock),
      .rst       (i_reset),
      .push      (vld_pipe[READ_LATENCY-1]),
      .push_data ({last_pipe[READ_LATENCY-1], bus.i_bram_data}),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign bus.o_renable  = renable;
   assign bus.o_raddress = raddress;
   assign bus.o_valid    = !fifo_empty;
   assign bus.o_data     = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];
   assign bus.o_last     = !fifo_empty && fifo_head[DATA_WIDTH];
   assign bus.o_busy     = (state != ST_IDLE);
   assign bus.o_done     = (state == ST_DONE);
endmodule

// File: tb/tb_output_pooling_reader.sv
// Testbench for output_pooling_reader: BRAM model with fixed read latency,
// reference drain order computed from channel/row/col loops, random stalls.
module tb_output_pooling_reader;
   localparam int DW = 32;
   localparam int CW = 7;
   localparam int COLW = 2;
   localparam int NB = 4;
   localparam int AW = 11;
   localparam int RL = 2;
   localparam int FD = RL + 2;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   output_pooling_reader_if #(
      .DATA_WIDTH(DW), .OUTPUT_CHANNEL_WIDTH(CW), .OUTPUT_COL_WIDTH(COLW),
      .OUTPUT_BRAM_NUM(NB), .OUTPUT_BRAM_ADDRESS_WIDTH(AW)
   ) bus ();

   output_pooling_reader #(
      .DATA_WIDTH(DW), .OUTPUT_CHANNEL_WIDTH(CW), .OUTPUT_COL_WIDTH(COLW),
      .OUTPUT_BRAM_NUM(NB), .OUTPUT_BRAM_DEPTH(1152), .READ_LATENCY(RL), .FIFO_DEPTH(FD)
   ) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   // memory contents: unique word per (bank, address)
   function automatic logic [31:0] mem_word(input int bank, input int addr);
      return {8'(bank), 8'h5A, 16'(addr)};
   endfunction

   // BRAM model: address/enable to data takes RL cycles
   logic [NB-1:0] m_bank [RL];
   logic [AW-1:0] m_addr [RL];
   logic [RL-1:0] m_vld;
   int            bram_idx;

   always @(posedge clk) begin
      m_vld[0]  <= |bus.o_renable;
      m_bank[0] <= bus.o_renable;
      m_addr[0] <= bus.o_raddress;
      for (int i = 1; i < RL; i++) begin
         m_vld[i]  <= m_vld[i-1];
         m_bank[i] <= m_bank[i-1];
         m_addr[i] <= m_addr[i-1];
      end
   end

   always_comb begin
      bram_idx = 0;
      for (int i = 0; i < NB; i++) if (m_bank[RL-1][i]) bram_idx = i;
      bus.i_bram_data = m_vld[RL-1] ? mem_word(bram_idx, int'(m_addr[RL-1])) : 32'hDEAD_BEEF;
   end

   // reference drain
   logic [31:0]   exp_data [$];
   bit            exp_last [$];
   logic [NB-1:0] exp_en   [$];
   logic [AW-1:0] exp_addr [$];
   logic [NB-1:0] obs_en   [$];
   logic [AW-1:0] obs_addr [$];

   task automatic build_expected(input int s, input int e, input int n);
      exp_data.delete(); exp_last.delete(); exp_en.delete(); exp_addr.delete();
      if (s > e || n == 0) return;
      for (int ch = s; ch <= e; ch++)
         for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
               int bank;
               int addr;
               bank = ch % NB;
               addr = ((ch / NB) * n * n + r * n + c) % (1 << AW);
               exp_en.push_back(NB'(1) << bank);
               exp_addr.push_back(AW'(addr));
               exp_data.push_back(mem_word(bank, addr));
               exp_last.push_back(ch == e && r == n - 1 && c == n - 1);
            end
   endtask

   task automatic run_drain(input string name, input int s, input int e, input int n,
                            input int stall_pct, input int busy_hold, input int abort_after);
      int          xfers;
      int          last_xfer_cyc;
      int          done_cyc;
      bit          done_seen;
      bit          prev_stall;
      logic [31:0] prev_data;
      logic        prev_last;
      build_expected(s, e, n);
      obs_en.delete(); obs_addr.delete();
      xfers = 0; last_xfer_cyc = -10; done_cyc = -1; done_seen = 0; prev_stall = 0;
      prev_data = '0; prev_last = 1'b0;
      bus.i_start_channel = CW'(s);
      bus.i_end_channel   = CW'(e);
      bus.i_pool_size     = COLW'(n);
      bus.i_reset_busy    = (busy_hold > 0);
      bus.i_ready         = 1'b1;
      bus.i_start         = 1'b1;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (abort_after > 0 && xfers == abort_after) begin
            rst = 1'b1;
            #1;
            checks++;
            if ({bus.o_renable, bus.o_raddress, bus.o_data, bus.o_valid, bus.o_last,
                 bus.o_busy, bus.o_done} !== '0) begin
               errors++;
               $display("FAIL %s abort_outputs: valid=%b data=%h renable=%b busy=%b required all zero",
                        name, bus.o_valid, bus.o_data, bus.o_renable, bus.o_busy);
            end
            @(posedge clk); #1;
            rst = 1'b0;
            @(posedge clk); #1;
            return;
         end
         bus.i_ready      = ($urandom_range(99) >= stall_pct);
         bus.i_reset_busy = (cyc < busy_hold);
         if (cyc == 0) begin
            checks++;
            if (bus.o_busy !== 1'b1) begin
               errors++;
               $display("FAIL %s busy_after_start: got %b required 1", name, bus.o_busy);
            end
         end
         if (busy_hold > 0 && cyc <= busy_hold) begin
            checks++;
            if (bus.o_renable !== '0) begin
               errors++;
               $display("FAIL %s renable_during_reset_busy cyc=%0d: got %b required 0000",
                        name, cyc, bus.o_renable);
            end
         end
         if (busy_hold > 0 && cyc == busy_hold + 1) begin
            checks++;
            if (bus.o_renable === '0) begin
               errors++;
               $display("FAIL %s first_read_after_busy: got %b required nonzero", name, bus.o_renable);
            end
         end
         if (bus.o_renable !== '0) begin
            obs_en.push_back(bus.o_renable);
            obs_addr.push_back(bus.o_raddress);
         end
         checks++;
         if (int'(dut.u_fifo.count) > FD) begin
            errors++;
            $display("FAIL %s fifo_count: got %0d required <= %0d", name, dut.u_fifo.count, FD);
         end
         if (prev_stall) begin
            checks++;
            if (bus.o_valid !== 1'b1 || bus.o_data !== prev_data || bus.o_last !== prev_last) begin
               errors++;
               $display("FAIL %s stall_hold: got valid=%b data=%h last=%b required 1 %h %b",
                        name, bus.o_valid, bus.o_data, bus.o_last, prev_data, prev_last);
            end
         end
         if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
            checks++;
            if (xfers >= exp_data.size()) begin
               errors++;
               $display("FAIL %s extra_word: got %h required no word", name, bus.o_data);
            end else if (bus.o_data !== exp_data[xfers] || bus.o_last !== exp_last[xfers]) begin
               errors++;
               $display("FAIL %s word[%0d]: got %h last=%b required %h last=%b",
                        name, xfers, bus.o_data, bus.o_last, exp_data[xfers], exp_last[xfers]);
            end
            xfers++;
            last_xfer_cyc = cyc;
         end
         if (bus.o_done === 1'b1) begin
            done_seen = 1;
            done_cyc  = cyc;
            break;
         end
         prev_stall = (bus.o_valid === 1'b1) && !bus.i_ready;
         prev_data  = bus.o_data;
         prev_last  = bus.o_last;
         @(posedge clk); #1;
      end
      checks++;
      if (!done_seen) begin
         errors++;
         $display("FAIL %s done_timeout: got no o_done required pulse", name);
      end else if (exp_data.size() == 0) begin
         if (done_cyc > 2) begin
            errors++;
            $display("FAIL %s degenerate_done_cycle: got %0d required <= 2", name, done_cyc);
         end
      end else if (done_cyc != last_xfer_cyc + 1) begin
         errors++;
         $display("FAIL %s done_cycle: got %0d required %0d", name, done_cyc, last_xfer_cyc + 1);
      end
      checks++;
      if (xfers != exp_data.size()) begin
         errors++;
         $display("FAIL %s word_count: got %0d required %0d", name, xfers, exp_data.size());
      end
      checks++;
      if (obs_en.size() != exp_en.size()) begin
         errors++;
         $display("FAIL %s read_count: got %0d required %0d", name, obs_en.size(), exp_en.size());
      end
      for (int i = 0; i < obs_en.size() && i < exp_en.size(); i++) begin
         checks++;
         if (obs_en[i] !== exp_en[i] || obs_addr[i] !== exp_addr[i]) begin
            errors++;
            $display("FAIL %s read[%0d]: got en=%b addr=%0d required en=%b addr=%0d",
                     name, i, obs_en[i], obs_addr[i], exp_en[i], exp_addr[i]);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
         errors++;
         $display("FAIL %s after_done: got done=%b busy=%b required 0 0", name, bus.o_done, bus.o_busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.i_start = 1'b0; bus.i_start_channel = '0; bus.i_end_channel = '0;
      bus.i_pool_size = '0; bus.i_reset_busy = 1'b0; bus.i_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.o_renable, bus.o_raddress, bus.o_data, bus.o_valid, bus.o_last,
           bus.o_busy, bus.o_done} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got renable=%b addr=%0d valid=%b busy=%b done=%b required all 0",
                  bus.o_renable, bus.o_raddress, bus.o_valid, bus.o_busy, bus.o_done);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_renable !== '0) begin
         errors++;
         $display("FAIL idle_after_reset: got valid=%b busy=%b renable=%b required 0 0 0",
                  bus.o_valid, bus.o_busy, bus.o_renable);
      end
   endtask

   task automatic test_basic();
      run_drain("basic", 0, 3, 2, 0, 0, 0);
      run_drain("upper", 4, 5, 2, 0, 0, 0);
   endtask

   task automatic test_backpressure();
      run_drain("backpressure", 0, 7, 3, 30, 0, 0);
   endtask

   task automatic test_reset_busy();
      run_drain("reset_busy", 1, 2, 2, 0, 10, 0);
   endtask

   task automatic test_degenerate();
      run_drain("degen_range", 5, 2, 2, 0, 0, 0);
      run_drain("degen_n0", 0, 3, 0, 0, 0, 0);
   endtask

   task automatic test_abort();
      run_drain("abort", 0, 7, 3, 0, 0, 5);
      run_drain("after_abort", 0, 0, 1, 0, 0, 0);
   endtask

   task automatic test_random();
      for (int k = 0; k < 3; k++) begin
         int s;
         s = int'($urandom_range(0, 20));
         run_drain("random", s, s + int'($urandom_range(0, 5)), int'($urandom_range(1, 3)), 50, 0, 0);
      end
      run_drain("max_channel", 126, 127, 1, 20, 0, 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_reset_busy();
      test_degenerate();
      test_abort();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
